imgproc_msg_sequencer: RTL

- Avalon-MM master that configures and drains the image-processor's memory-mapped slave, so hardware can consume red bounding-box messages without the CPU.
- After reset it checks the processor ID, flushes the message FIFO and programs the box colour.
- It then polls the status register periodically, reads each complete 3-word "RBB" message, and publishes the decoded box coordinates on a pulsed output.
- It sits between the image processor's slave port and downstream consumers (for example a motor or steering controller).

---
 rtl/imgproc_msg_sequencer.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/imgproc_msg_sequencer.sv
// Avalon-MM master for the image processor's slave port: checks the ID, flushes the
// message FIFO, programs the box colour, then polls and drains 3-word box messages.
//
// state     | meaning
// ----------+------------------------------------------------------------
// RD_ID     | read the ID register (addr 2), fault on mismatch
// FLUSH     | write 0x10 to status (addr 0) to empty the message FIFO
// WR_COL    | write the box colour (addr 3)
// IDLE_WAIT | poll interval timer running
// RD_STAT   | read status (addr 0), drain if at least one full message
// RD_HDR    | read header word, resync via FLUSH if it is not the message ID
// RD_TL     | read top-left corner into shadow registers
// RD_BR     | read bottom-right corner into shadow registers
// PUBLISH   | copy shadow box to outputs and pulse box_valid
// FAULT     | terminal, no bus activity until reset
module imgproc_msg_sequencer #(
  parameter int unsigned POLL_INTERVAL  = 1000,
  parameter logic [31:0] ID_VALUE       = 32'h1234EEE2,
  parameter logic [31:0] MSG_ID         = 32'h00524242,
  parameter logic [23:0] BB_COL_DEFAULT = 24'h00ff00
) (
  input  logic        clk,
  input  logic        reset,
  output logic        m_chipselect,
  output logic        m_read,
  output logic        m_write,
  output logic [2:0]  m_address,
  output logic [31:0] m_writedata,
  input  logic [31:0] m_readdata,
  input  logic        col_req,
  input  logic [23:0] col_value,
  output logic        box_valid,
  output logic [10:0] box_x_min,
  output logic [10:0] box_y_min,
  output logic [10:0] box_x_max,
  output logic [10:0] box_y_max,
  output logic        id_fault,
  output logic [7:0]  sync_errors,
  output logic        busy
);

  localparam int unsigned CNT_W     = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  localparam logic [CNT_W-1:0] POLL_LOAD = CNT_W'(POLL_INTERVAL - 1);
  localparam logic [2:0]  ADDR_STAT = 3'd0;
  localparam logic [2:0]  ADDR_MSG  = 3'd1;
  localparam logic [2:0]  ADDR_ID   = 3'd2;
  localparam logic [2:0]  ADDR_COL  = 3'd3;
  localparam logic [31:0] FLUSH_CMD = 32'h0000_0010;

  typedef enum logic [3:0] {
    RD_ID, FLUSH, WR_COL, IDLE_WAIT, RD_STAT, RD_HDR, RD_TL, RD_BR, PUBLISH, FAULT
  } state_t;

  // PH_STB: strobe visible on the bus, PH_SMP: read data valid, PH_INIT: first read after reset
  typedef enum logic [1:0] {PH_STB, PH_SMP, PH_INIT} phase_t;

  state_t           state;
  phase_t           phase;
  logic [CNT_W-1:0] poll_cnt;
  logic             col_pend;
  logic [23:0]      col_val;
  logic             first_pass;
  logic [10:0]      sh_x_min, sh_y_min, sh_x_max, sh_y_max;
  logic [23:0]      col_next;

  // A request arriving in the cycle the colour write is launched must win
  assign col_next     = col_req ? col_value : col_val;
  assign m_chipselect = m_read | m_write;
  assign busy         = (state != IDLE_WAIT) && (state != FAULT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RD_ID;
      phase       <= PH_INIT;
      m_read      <= 1'b0;
      m_write     <= 1'b0;
      m_address   <= '0;
      m_writedata <= '0;
      poll_cnt    <= '0;
      col_pend    <= 1'b0;
      col_val     <= BB_COL_DEFAULT;
      first_pass  <= 1'b1;
      sh_x_min    <= '0;
      sh_y_min    <= '0;
      sh_x_max    <= '0;
      sh_y_max    <= '0;
      box_x_min   <= '0;
      box_y_min   <= '0;
      box_x_max   <= '0;
      box_y_max   <= '0;
      box_valid   <= 1'b0;
      id_fault    <= 1'b0;
      sync_errors <= '0;
    end else begin
      m_read    <= 1'b0;
      m_write   <= 1'b0;
      box_valid <= 1'b0;
      case (state)
        RD_ID: begin
          if (phase == PH_INIT) begin
            m_read    <= 1'b1;
            m_address <= ADDR_ID;
            phase     <= PH_STB;
          end else if (phase == PH_STB) begin
            phase <= PH_SMP;
          end else if (m_readdata != ID_VALUE) begin
            state    <= FAULT;
            id_fault <= 1'b1;
          end else begin
            state       <= FLUSH;
            phase       <= PH_STB;
            m_write     <= 1'b1;
            m_address   <= ADDR_STAT;
            m_writedata <= FLUSH_CMD;
          end
        end
        FLUSH: begin
          state       <= WR_COL;
          m_write     <= 1'b1;
          m_address   <= ADDR_COL;
          m_writedata <= {8'h00, first_pass ? BB_COL_DEFAULT : col_next};
        end
        WR_COL: begin
          // A request seen before the first colour write stays pending for the next expiry
          if (!first_pass) col_pend <= 1'b0;
          first_pass <= 1'b0;
          state      <= IDLE_WAIT;
          poll_cnt   <= POLL_LOAD;
        end
        IDLE_WAIT: begin
          if (poll_cnt != '0) begin
            poll_cnt <= poll_cnt - 1'b1;
          end else if (col_pend) begin
            state       <= WR_COL;
            phase       <= PH_STB;
            m_write     <= 1'b1;
            m_address   <= ADDR_COL;
            m_writedata <= {8'h00, col_next};
          end else begin
            state     <= RD_STAT;
            phase     <= PH_STB;
            m_read    <= 1'b1;
            m_address <= ADDR_STAT;
          end
        end
        RD_STAT: begin
          if (phase == PH_STB) begin
            phase <= PH_SMP;
          end else if (m_readdata[15:8] >= 8'd3) begin
            state     <= RD_HDR;
            phase     <= PH_STB;
            m_read    <= 1'b1;
            m_address <= ADDR_MSG;
          end else begin
            state    <= IDLE_WAIT;
            poll_cnt <= POLL_LOAD;
          end
        end
        RD_HDR: begin
          if (phase == PH_STB) begin
            phase <= PH_SMP;
          end else if (m_readdata == MSG_ID) begin
            state     <= RD_TL;
            phase     <= PH_STB;
            m_read    <= 1'b1;
            m_address <= ADDR_MSG;
          end else begin
            if (sync_errors != 8'hFF) sync_errors <= sync_errors + 8'd1;
            state       <= FLUSH;
            phase       <= PH_STB;
            m_write     <= 1'b1;
            m_address   <= ADDR_STAT;
            m_writedata <= FLUSH_CMD;
          end
        end
        RD_TL: begin
          if (phase == PH_STB) begin
            phase <= PH_SMP;
          end else begin
            sh_x_min  <= m_readdata[26:16];
            sh_y_min  <= m_readdata[10:0];
            state     <= RD_BR;
            phase     <= PH_STB;
            m_read    <= 1'b1;
            m_address <= ADDR_MSG;
          end
        end
        RD_BR: begin
          if (phase == PH_STB) begin
            phase <= PH_SMP;
          end else begin
            sh_x_max <= m_readdata[26:16];
            sh_y_max <= m_readdata[10:0];
            state    <= PUBLISH;
            phase    <= PH_STB;
          end
        end
        PUBLISH: begin
          box_x_min <= sh_x_min;
          box_y_min <= sh_y_min;
          box_x_max <= sh_x_max;
          box_y_max <= sh_y_max;
          box_valid <= 1'b1;
          state     <= RD_STAT;
          phase     <= PH_STB;
          m_read    <= 1'b1;
          m_address <= ADDR_STAT;
        end
        FAULT: begin
          state <= FAULT;
        end
        default: begin
          state <= RD_ID;
          phase <= PH_INIT;
        end
      endcase
      if (col_req) begin
        col_pend <= 1'b1;
        col_val  <= col_value;
      end
    end
  end

endmodule
